// File: rtl/visu_pkg.sv
// Shared types and constants for the sparkle overlay: slot record, FSM states,
// visible frame size and the life-to-brightness mapping.
package visu_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [4:0] life;
  } sparkle_slot_t;

  typedef enum logic [1:0] {IDLE, AGE, SPAWN} spk_state_t;

  function automatic logic [3:0] level_of(input logic [4:0] life);
    return (life > 5'd15) ? 4'd15 : life[3:0];
  endfunction

  function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sparkle_hit_test.sv
// Combinational footprint test of one sparkle slot against a pixel query.
// Level is forced to 0 on a miss so the caller can max-reduce directly.
module sparkle_hit_test
  import visu_pkg::*;
#(
  parameter int RADIUS = 2
) (
  input  sparkle_slot_t i_slot,
  input  logic [9:0]    i_px_x,
  input  logic [9:0]    i_px_y,
  output logic          o_hit,
  output logic [3:0]    o_level
);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic        [10:0] adx;
  logic        [10:0] ady;

  // Signed differences clip the footprint at frame edges instead of wrapping.
  assign dx  = $signed({1'b0, i_px_x}) - $signed({1'b0, i_slot.x});
  assign dy  = $signed({1'b0, i_px_y}) - $signed({2'b00, i_slot.y});
  assign adx = dx[10] ? 11'(-dx) : 11'(dx);
  assign ady = dy[10] ? 11'(-dy) : 11'(dy);

  assign o_hit   = (i_slot.life != 5'd0) && (adx <= 11'(RADIUS)) && (ady <= 11'(RADIUS));
  assign o_level = o_hit ? level_of(i_slot.life) : 4'd0;

endmodule

// File: rtl/sparkle_spawner.sv
// Per-frame sparkle slot manager: ages slots and spawns new ones from random bits
// gated by audio amplitude, and answers registered per-pixel brightness queries.
module sparkle_spawner
  import visu_pkg::*;
#(
  parameter int N_SLOT      = 8,
  parameter int SPAWN_TRIES = 2,
  parameter int RADIUS      = 2,
  parameter int LIFE_BASE   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_random,
  input  logic [7:0]  i_amp,
  input  logic        i_frame_start,
  input  logic        i_px_valid,
  input  logic [9:0]  i_px_x,
  input  logic [9:0]  i_px_y,
  output logic        o_sparkle_on,
  output logic [3:0]  o_sparkle_level,
  output logic        o_busy,
  output logic [4:0]  o_active_cnt
);

  sparkle_slot_t slots_q [N_SLOT];
  sparkle_slot_t slots_d [N_SLOT];
  spk_state_t    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    active_cnt_q, active_cnt_d;
  logic          sparkle_on_q, sparkle_on_d;
  logic [3:0]    level_q, level_d;

  logic [9:0] rnd_x;
  logic [8:0] rnd_y;
  logic [7:0] rnd_thr;
  logic [3:0] rnd_lseed;
  logic       unused_random;

  assign rnd_x         = i_random[9:0];
  assign rnd_y         = i_random[18:10];
  assign rnd_thr       = i_random[26:19];
  assign rnd_lseed     = i_random[30:27];
  assign unused_random = ^i_random[47:31];

  logic       free_found;
  logic [4:0] free_idx;
  logic       try_ok;

  // Lowest-index free slot wins; scanning downward leaves the lowest one last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 5'd0;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (slots_q[i].life == 5'd0) begin
        free_found = 1'b1;
        free_idx   = 5'(i);
      end
    end
  end

  assign try_ok = (i_amp > rnd_thr) && (rnd_x < 10'(H_ACTIVE)) &&
                  (rnd_y < 9'(V_ACTIVE)) && free_found;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    for (int i = 0; i < N_SLOT; i++) slots_d[i] = slots_q[i];
    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          state_d = AGE;
          idx_d   = 5'd0;
        end
      end
      AGE: begin
        for (int i = 0; i < N_SLOT; i++) begin
          if (5'(i) == idx_q && slots_q[i].life != 5'd0)
            slots_d[i].life = slots_q[i].life - 5'd1;
        end
        if (idx_q == 5'(N_SLOT - 1)) begin
          state_d = SPAWN;
          idx_d   = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      SPAWN: begin
        for (int i = 0; i < N_SLOT; i++) begin
          if (try_ok && 5'(i) == free_idx) begin
            slots_d[i].x    = rnd_x;
            slots_d[i].y    = rnd_y;
            slots_d[i].life = 5'(LIFE_BASE) + {1'b0, rnd_lseed};
          end
        end
        if (idx_q == 5'(SPAWN_TRIES - 1)) begin
          state_d = IDLE;
          idx_d   = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

  always_comb begin
    active_cnt_d = 5'd0;
    for (int i = 0; i < N_SLOT; i++)
      if (slots_q[i].life != 5'd0) active_cnt_d = active_cnt_d + 5'd1;
  end

  logic [N_SLOT-1:0] slot_hit;
  logic [3:0]        slot_level [N_SLOT];
  logic [3:0]        leaf [16];
  logic [3:0]        lvl1 [8];
  logic [3:0]        lvl2 [4];
  logic [3:0]        lvl3 [2];
  logic [3:0]        max_level;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_hit
      sparkle_hit_test #(.RADIUS(RADIUS)) u_hit (
        .i_slot  (slots_q[gi]),
        .i_px_x  (i_px_x),
        .i_px_y  (i_px_y),
        .o_hit   (slot_hit[gi]),
        .o_level (slot_level[gi])
      );
    end
    // Fixed 16-leaf tree covers every legal N_SLOT; missing leaves read as 0.
    for (gi = 0; gi < 16; gi++) begin : g_leaf
      if (gi < N_SLOT) begin : g_used
        assign leaf[gi] = slot_level[gi];
      end else begin : g_pad
        assign leaf[gi] = 4'd0;
      end
    end
    for (gi = 0; gi < 8; gi++) begin : g_l1
      assign lvl1[gi] = max4(leaf[2*gi], leaf[2*gi+1]);
    end
    for (gi = 0; gi < 4; gi++) begin : g_l2
      assign lvl2[gi] = max4(lvl1[2*gi], lvl1[2*gi+1]);
    end
    for (gi = 0; gi < 2; gi++) begin : g_l3
      assign lvl3[gi] = max4(lvl2[2*gi], lvl2[2*gi+1]);
    end
  endgenerate

  assign max_level    = max4(lvl3[0], lvl3[1]);
  assign sparkle_on_d = i_px_valid && (|slot_hit);
  assign level_d      = i_px_valid ? max_level : 4'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_SLOT; i++) slots_q[i] <= '0;
      state_q      <= IDLE;
      idx_q        <= 5'd0;
      active_cnt_q <= 5'd0;
      sparkle_on_q <= 1'b0;
      level_q      <= 4'd0;
    end else begin
      for (int i = 0; i < N_SLOT; i++) slots_q[i] <= slots_d[i];
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_cnt_q <= active_cnt_d;
      sparkle_on_q <= sparkle_on_d;
      level_q      <= level_d;
    end
  end

  assign o_sparkle_on    = sparkle_on_q;
  assign o_sparkle_level = level_q;
  assign o_busy          = (state_q != IDLE);
  assign o_active_cnt    = active_cnt_q;

endmodule

// File: tb/tb_sparkle_spawner.sv
// Directed bench for sparkle_spawner: spawn gating, bounds, fill/expiry, busy
// timing, query footprint and reset behaviour.
module tb_sparkle_spawner;

  logic        clk;
  logic        rst;
  logic [47:0] random_v;
  logic [7:0]  amp;
  logic        frame_start;
  logic        px_valid;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        sparkle_on;
  logic [3:0]  sparkle_level;
  logic        busy;
  logic [4:0]  active_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sparkle_spawner dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_random        (random_v),
    .i_amp           (amp),
    .i_frame_start   (frame_start),
    .i_px_valid      (px_valid),
    .i_px_x          (px_x),
    .i_px_y          (px_y),
    .o_sparkle_on    (sparkle_on),
    .o_sparkle_level (sparkle_level),
    .o_busy          (busy),
    .o_active_cnt    (active_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mk_rand(input int x, input int y, input int thr, input int ls);
    logic [47:0] r;
    r          = '0;
    r[9:0]     = x[9:0];
    r[18:10]   = y[8:0];
    r[26:19]   = thr[7:0];
    r[30:27]   = ls[3:0];
    r[47:31]   = 17'h1abcd;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic run_frame(output int busy_len);
    int n;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
    step();
    busy_len = n;
  endtask

  task automatic run_query(input int x, input int y, output logic on, output logic [3:0] lvl);
    px_valid = 1'b1;
    px_x     = x[9:0];
    px_y     = y[9:0];
    step();
    on  = sparkle_on;
    lvl = sparkle_level;
    px_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic on;
    logic [3:0] lvl;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({sparkle_on, sparkle_level, busy, active_cnt} !== 11'd0)
      $display("FAIL reset_outputs got on=%b lvl=%0d busy=%b cnt=%0d want all 0",
               sparkle_on, sparkle_level, busy, active_cnt);
    else pass_cnt++;
    rst = 1'b0;
    step();
    run_query(0, 0, on, lvl);
    total_cnt++;
    if (on !== 1'b0 || lvl !== 4'd0)
      $display("FAIL reset_query got on=%b lvl=%0d want on=0 lvl=0", on, lvl);
    else pass_cnt++;
    $display("test_reset: on=%b lvl=%0d cnt=%0d", on, lvl, active_cnt);
  endtask

  task automatic test_spawn_and_query();
    int blen;
    logic on;
    logic [3:0] lvl;
    do_reset();
    amp      = 8'd255;
    random_v = mk_rand(100, 50, 0, 0);
    run_frame(blen);
    total_cnt++;
    if (blen !== 10) $display("FAIL busy_len got %0d want 10", blen);
    else pass_cnt++;
    total_cnt++;
    if (active_cnt !== 5'd2) $display("FAIL spawn_cnt got %0d want 2", active_cnt);
    else pass_cnt++;
    run_query(101, 52, on, lvl);
    total_cnt++;
    if (on !== 1'b1 || lvl !== 4'd8)
      $display("FAIL query_inside got on=%b lvl=%0d want on=1 lvl=8", on, lvl);
    else pass_cnt++;
    run_query(98, 48, on, lvl);
    total_cnt++;
    if (on !== 1'b1 || lvl !== 4'd8)
      $display("FAIL query_corner got on=%b lvl=%0d want on=1 lvl=8", on, lvl);
    else pass_cnt++;
    run_query(103, 50, on, lvl);
    total_cnt++;
    if (on !== 1'b0 || lvl !== 4'd0)
      $display("FAIL query_outside got on=%b lvl=%0d want on=0 lvl=0", on, lvl);
    else pass_cnt++;
    run_query(100, 47, on, lvl);
    total_cnt++;
    if (on !== 1'b0) $display("FAIL query_above got on=%b want 0", on);
    else pass_cnt++;
    $display("test_spawn_and_query: busy=%0d cnt=%0d", blen, active_cnt);
  endtask

  task automatic test_low_amp();
    int blen;
    do_reset();
    amp = 8'd0;
    for (int f = 0; f < 10; f++) begin
      random_v = mk_rand(f * 37, f * 23, f * 11, f);
      run_frame(blen);
    end
    total_cnt++;
    if (active_cnt !== 5'd0) $display("FAIL amp0_nospawn got %0d want 0", active_cnt);
    else pass_cnt++;
    amp      = 8'd77;
    random_v = mk_rand(200, 100, 77, 1);
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd0) $display("FAIL amp_eq_thr got %0d want 0", active_cnt);
    else pass_cnt++;
    amp = 8'd78;
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd2) $display("FAIL amp_gt_thr got %0d want 2", active_cnt);
    else pass_cnt++;
    $display("test_low_amp: cnt=%0d", active_cnt);
  endtask

  task automatic test_reject_bounds();
    int blen;
    logic on;
    logic [3:0] lvl;
    do_reset();
    amp      = 8'd255;
    random_v = mk_rand(700, 50, 0, 0);
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd0) $display("FAIL reject_x700 got %0d want 0", active_cnt);
    else pass_cnt++;
    random_v = mk_rand(100, 500, 0, 0);
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd0) $display("FAIL reject_y500 got %0d want 0", active_cnt);
    else pass_cnt++;
    random_v = mk_rand(639, 479, 0, 0);
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd2) $display("FAIL accept_edge got %0d want 2", active_cnt);
    else pass_cnt++;
    run_query(637, 477, on, lvl);
    total_cnt++;
    if (on !== 1'b1 || lvl !== 4'd8)
      $display("FAIL query_edge got on=%b lvl=%0d want on=1 lvl=8", on, lvl);
    else pass_cnt++;
    random_v = mk_rand(640, 0, 0, 0);
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd2) $display("FAIL reject_x640 got %0d want 2", active_cnt);
    else pass_cnt++;
    random_v = mk_rand(0, 480, 0, 0);
    run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd2) $display("FAIL reject_y480 got %0d want 2", active_cnt);
    else pass_cnt++;
    $display("test_reject_bounds: cnt=%0d", active_cnt);
  endtask

  task automatic test_fill_and_expire();
    int blen;
    logic on;
    logic [3:0] lvl;
    do_reset();
    amp      = 8'd255;
    random_v = mk_rand(10, 10, 0, 3);
    for (int f = 0; f < 4; f++) run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd8) $display("FAIL fill_cnt got %0d want 8", active_cnt);
    else pass_cnt++;
    random_v = mk_rand(200, 200, 0, 0);
    run_frame(blen);
    run_query(200, 200, on, lvl);
    total_cnt++;
    if (on !== 1'b0) $display("FAIL no_overwrite got on=%b want 0", on);
    else pass_cnt++;
    run_query(10, 10, on, lvl);
    total_cnt++;
    if (on !== 1'b1 || lvl !== 4'd10)
      $display("FAIL fill_max_level got on=%b lvl=%0d want on=1 lvl=10", on, lvl);
    else pass_cnt++;
    amp = 8'd0;
    for (int f = 0; f < 7; f++) run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd6) $display("FAIL partial_expire got %0d want 6", active_cnt);
    else pass_cnt++;
    for (int f = 0; f < 3; f++) run_frame(blen);
    total_cnt++;
    if (active_cnt !== 5'd0) $display("FAIL full_expire got %0d want 0", active_cnt);
    else pass_cnt++;
    $display("test_fill_and_expire: cnt=%0d", active_cnt);
  endtask

  task automatic test_busy_ignore_and_reset();
    int n;
    logic on;
    logic [3:0] lvl;
    do_reset();
    amp      = 8'd255;
    random_v = mk_rand(100, 50, 0, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      frame_start = (n == 3);
      step();
    end
    frame_start = 1'b0;
    total_cnt++;
    if (n !== 10) $display("FAIL busy_ignore_len got %0d want 10", n);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (busy !== 1'b0 || active_cnt !== 5'd2)
      $display("FAIL busy_not_queued got busy=%b cnt=%0d want busy=0 cnt=2", busy, active_cnt);
    else pass_cnt++;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || active_cnt !== 5'd0)
      $display("FAIL reset_mid_age got busy=%b cnt=%0d want busy=0 cnt=0", busy, active_cnt);
    else pass_cnt++;
    run_query(100, 50, on, lvl);
    total_cnt++;
    if (on !== 1'b0 || lvl !== 4'd0)
      $display("FAIL reset_cleared_query got on=%b lvl=%0d want on=0 lvl=0", on, lvl);
    else pass_cnt++;
    $display("test_busy_ignore_and_reset: busy_len=%0d", n);
  endtask

  initial begin
    rst         = 1'b1;
    random_v    = '0;
    amp         = 8'd0;
    frame_start = 1'b0;
    px_valid    = 1'b0;
    px_x        = '0;
    px_y        = '0;
    test_reset();
    test_spawn_and_query();
    test_low_amp();
    test_reject_bounds();
    test_fill_and_expire();
    test_busy_ignore_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
